// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the narrowing store unit: size codes, FSM states
// and the alignment rule shared by the FSM.
package store_narrow_rmw_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    localparam int CNT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    // A store is rejected for an illegal size or an address not aligned to its size.
    function automatic logic store_is_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            SZ_BAD:  bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: places narrowed store data into the old memory word
// (little-endian) and reports whether truncation discarded information.
module store_lane_merge
    import store_narrow_rmw_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  byte_off,
    input  logic        sel,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] merged,
    output logic        trunc_ovf
);

    always_comb begin
        merged    = old_word;
        trunc_ovf = 1'b0;
        case (size)
            SZ_BYTE: begin
                case (byte_off)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
                trunc_ovf = (wdata[31:8] != {24{sel & wdata[7]}});
            end
            SZ_HALF: begin
                if (byte_off[1]) begin
                    merged[31:16] = wdata[15:0];
                end else begin
                    merged[15:0] = wdata[15:0];
                end
                trunc_ovf = (wdata[31:16] != {16{sel & wdata[15]}});
            end
            SZ_WORD: merged = wdata;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_narrow_rmw.sv
// Narrowing store unit: word stores write directly, byte/half stores do a
// read-modify-write against word-addressed data memory.
module store_narrow_rmw
    import store_narrow_rmw_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              ready,
    input  logic [1:0]        size,
    input  logic              sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr_en,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic              trunc_ovf
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              sel_q, sel_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              trunc_ovf_q, trunc_ovf_d;
    logic              ready_q, ready_d;

    logic              in_idle;
    logic [1:0]        m_size;
    logic [1:0]        m_off;
    logic              m_sel;
    logic [31:0]       m_wdata;
    logic [31:0]       merged;
    logic              merge_trunc;

    // Word stores merge straight from the live inputs at accept; sub-word
    // stores merge from the captured request when read data arrives.
    assign in_idle = (state_q == ST_IDLE);
    assign m_size  = in_idle ? size        : size_q;
    assign m_off   = in_idle ? addr[1:0]   : off_q;
    assign m_sel   = in_idle ? sel         : sel_q;
    assign m_wdata = in_idle ? wdata       : wdata_q;

    store_lane_merge u_merge (
        .size      (m_size),
        .byte_off  (m_off),
        .sel       (m_sel),
        .wdata     (m_wdata),
        .old_word  (mem_rdata),
        .merged    (merged),
        .trunc_ovf (merge_trunc)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        sel_d       = sel_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_wdata_d = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        trunc_ovf_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    size_d     = size;
                    sel_d      = sel;
                    off_d      = addr[1:0];
                    wdata_d    = wdata;
                    mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
                    if (store_is_bad(size, addr[1:0])) begin
                        state_d = ST_FAIL;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (size == SZ_WORD) begin
                        state_d     = ST_WRITE;
                        mem_wr_en_d = 1'b1;
                        mem_wdata_d = merged;
                        done_d      = 1'b1;
                    end else begin
                        state_d     = ST_READ;
                        mem_rd_en_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(RD_LAT - 1);
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_WRITE;
                    mem_wr_en_d = 1'b1;
                    mem_wdata_d = merged;
                    done_d      = 1'b1;
                    trunc_ovf_d = merge_trunc;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE, ST_FAIL: begin
                state_d    = ST_IDLE;
                mem_addr_d = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            size_q      <= '0;
            sel_q       <= 1'b0;
            off_q       <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            trunc_ovf_q <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            sel_q       <= sel_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            trunc_ovf_q <= trunc_ovf_d;
            ready_q     <= ready_d;
        end
    end

    assign ready     = ready_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign err       = err_q;
    assign trunc_ovf = trunc_ovf_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Bench for store_narrow_rmw: two instances (RD_LAT=1 and RD_LAT=3) share the
// request data and are checked cycle by cycle against an arithmetic reference model.
module tb_store_narrow_rmw;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req1, req3;
    logic [1:0]  size;
    logic        sel;
    logic [31:0] addr, wdata;

    logic        ready1, rd1, wr1, done1, err1, tr1;
    logic [31:0] maddr1, mwdata1, rdata1;
    logic        ready3, rd3, wr3, done3, err3, tr3;
    logic [31:0] maddr3, mwdata3, rdata3;

    logic [31:0] mem [256];
    int          cur_idx = 0;
    logic [3:0]  pipe1 = '0;
    logic [3:0]  pipe3 = '0;
    int          wcnt1 = 0;
    int          wcnt3 = 0;
    int          n_compared = 0;
    int          n_mismatched = 0;
    int          op_num = 0;

    always #5 clk = ~clk;

    store_narrow_rmw #(.RD_LAT(1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .ready(ready1), .size(size), .sel(sel),
        .addr(addr), .wdata(wdata), .mem_addr(maddr1), .mem_rd_en(rd1), .mem_rdata(rdata1),
        .mem_wr_en(wr1), .mem_wdata(mwdata1), .done(done1), .err(err1), .trunc_ovf(tr1)
    );

    store_narrow_rmw #(.RD_LAT(3), .ADDR_W(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .ready(ready3), .size(size), .sel(sel),
        .addr(addr), .wdata(wdata), .mem_addr(maddr3), .mem_rd_en(rd3), .mem_rdata(rdata3),
        .mem_wr_en(wr3), .mem_wdata(mwdata3), .done(done3), .err(err3), .trunc_ovf(tr3)
    );

    // Memory responders: read data is valid only in the cycle RD_LAT after the strobe.
    always @(posedge clk) begin
        pipe1 <= {pipe1[2:0], rd1};
        pipe3 <= {pipe3[2:0], rd3};
    end

    always @(negedge clk) begin
        rdata1 = (pipe1[0] === 1'b1) ? mem[cur_idx] : $urandom;
        rdata3 = (pipe3[2] === 1'b1) ? mem[cur_idx] : $urandom;
        if (wr1 === 1'b1) wcnt1 = wcnt1 + 1;
        if (wr3 === 1'b1) wcnt3 = wcnt3 + 1;
    end

    function automatic bit ref_bad(input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        return (sz == 2'd3) || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0);
    endfunction

    // Truncation loses information exactly when the value does not fit in N bits.
    function automatic bit ref_trunc(input logic [1:0] sz, input logic s, input logic [31:0] wd);
        int sv;
        sv = $signed(wd);
        if (sz == 2'd0) return s ? (sv < -128 || sv > 127) : (wd > 32'd255);
        if (sz == 2'd1) return s ? (sv < -32768 || sv > 32767) : (wd > 32'd65535);
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        int          sh;
        logic [31:0] mask;
        if (sz == 2'd2) return wd;
        if (sz == 2'd0) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
        end else begin
            sh   = 16 * (int'(a[1:0]) / 2);
            mask = 32'h0000_FFFF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [1:0] sz, input logic s,
                                 input logic [31:0] a, input logic [31:0] wd);
        size  = sz;
        sel   = s;
        addr  = a;
        wdata = wd;
        req1  = m[0];
        req3  = m[1];
    endtask

    task automatic checkCycle(input string name, input int k, input int last, input bit bad,
                              input bit sub, input bit tr, input logic [31:0] expw,
                              input logic [31:0] expa, input logic [5:0] strobes,
                              input logic [31:0] obs_addr, input logic [31:0] obs_data);
        logic [5:0] exp_s;
        exp_s = {k > last, sub && k == 1, !bad && k == last, k == last, bad && k == last,
                 tr && k == last};
        checkOutput($sformatf("op%0d %s k%0d strobes", op_num, name, k), {26'd0, strobes},
                    {26'd0, exp_s});
        if (k <= last)
            checkOutput($sformatf("op%0d %s k%0d mem_addr", op_num, name, k), obs_addr, expa);
        if (k == last && !bad)
            checkOutput($sformatf("op%0d %s mem_wdata", op_num, name), obs_data, expw);
    endtask

    // Called just after the accept edge; follows the op until the DUT(s) are idle again.
    task automatic watchOp(input logic [1:0] m, input logic [1:0] sz, input logic s,
                           input logic [31:0] a, input logic [31:0] wd, input bit use_next,
                           input logic [1:0] nsz, input logic nsel, input logic [31:0] na,
                           input logic [31:0] nwd);
        bit          bad, sub, tr;
        logic [31:0] old, expw, expa;
        int          last1, last3, max_k;
        bad     = ref_bad(sz, a);
        sub     = !bad && sz != 2'd2;
        tr      = sub && ref_trunc(sz, s, wd);
        cur_idx = int'(a[9:2]);
        old     = mem[cur_idx];
        expw    = ref_merge(old, sz, a, wd);
        expa    = a & 32'hFFFF_FFFC;
        last1   = sub ? 3 : 1;
        last3   = sub ? 5 : 1;
        max_k   = m[1] ? last3 + 1 : last1 + 1;
        for (int k = 1; k <= max_k; k++) begin
            @(negedge clk);
            if (m[0])
                checkCycle("lat1", k, last1, bad, sub, tr, expw, expa,
                           {ready1, rd1, wr1, done1, err1, tr1}, maddr1, mwdata1);
            if (m[1])
                checkCycle("lat3", k, last3, bad, sub, tr, expw, expa,
                           {ready3, rd3, wr3, done3, err3, tr3}, maddr3, mwdata3);
            if (k == 2) begin
                size  = use_next ? nsz : 2'($urandom_range(0, 3));
                sel   = use_next ? nsel : 1'($urandom_range(0, 1));
                addr  = use_next ? na : $urandom;
                wdata = use_next ? nwd : $urandom;
            end
        end
        if (!bad) mem[cur_idx] = expw;
        op_num++;
    endtask

    task automatic runOp(input logic [1:0] sz, input logic s, input logic [31:0] a,
                         input logic [31:0] wd);
        applyStimulus(2'b11, sz, s, a, wd);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        req3 = 1'b0;
        watchOp(2'b11, sz, s, a, wd, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        int          w1, w3;
        logic [1:0]  rsz;
        logic [31:0] ra, rwd;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst_n = 1'b0;
        applyStimulus(2'b00, 2'd0, 1'b0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset lat1 strobes", {26'd0, ready1, rd1, wr1, done1, err1, tr1}, 32'h20);
        checkOutput("reset lat3 strobes", {26'd0, ready3, rd3, wr3, done3, err3, tr3}, 32'h20);
        checkOutput("reset lat1 addr/data", maddr1 | mwdata1, 32'd0);
        checkOutput("reset lat3 addr/data", maddr3 | mwdata3, 32'd0);
        rst_n = 1'b1;

        // Reset while a byte store is waiting for read data.
        w1 = wcnt1;
        w3 = wcnt3;
        applyStimulus(2'b11, 2'd0, 1'b0, 32'h104, 32'h5A);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        req3 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midreset lat1 strobes", {26'd0, ready1, rd1, wr1, done1, err1, tr1}, 32'h20);
        checkOutput("midreset lat3 strobes", {26'd0, ready3, rd3, wr3, done3, err3, tr3}, 32'h20);
        checkOutput("midreset addr/data", maddr1 | mwdata1 | maddr3 | mwdata3, 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("midreset lat1 no write", 32'(wcnt1 - w1), 32'd0);
        checkOutput("midreset lat3 no write", 32'(wcnt3 - w3), 32'd0);
        runOp(2'd0, 1'b1, 32'h108, 32'hFFFF_FF80);

        mem[64] = 32'h1122_3344;
        runOp(2'd0, 1'b0, 32'h103, 32'h0000_00AB);
        mem[128] = 32'hDEAD_BEEF;
        runOp(2'd1, 1'b1, 32'h202, 32'hFFFF_8001);
        mem[128] = 32'hDEAD_BEEF;
        runOp(2'd1, 1'b1, 32'h202, 32'h0000_8001);
        runOp(2'd2, 1'b0, 32'h40, 32'hCAFE_F00D);
        runOp(2'd1, 1'b0, 32'h11, 32'h1234_5678);
        runOp(2'd3, 1'b1, 32'h20, 32'hFFFF_FFFF);
        runOp(2'd2, 1'b0, 32'h22, 32'h0BAD_0BAD);

        // Hold req through a byte store on the RD_LAT=3 instance; the second
        // request is presented during WAIT and must only be taken after WRITE.
        applyStimulus(2'b10, 2'd0, 1'b0, 32'h301, 32'h0000_00C3);
        @(posedge clk);
        #1;
        watchOp(2'b10, 2'd0, 1'b0, 32'h301, 32'h0000_00C3, 1'b1, 2'd1, 1'b1, 32'h306,
                32'hFFFF_9000);
        @(posedge clk);
        #1;
        req3 = 1'b0;
        watchOp(2'b10, 2'd1, 1'b1, 32'h306, 32'hFFFF_9000, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 40; i++) begin
            rsz = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & ((rsz == 2'd2) ? 32'hFFFF_FFFC :
                                                     (rsz == 2'd1) ? 32'hFFFF_FFFE : ra);
            case ($urandom_range(0, 3))
                0:       rwd = $urandom;
                1:       rwd = 32'($signed(8'($urandom)));
                2:       rwd = 32'($signed(16'($urandom)));
                default: rwd = 32'($urandom_range(0, 255));
            endcase
            runOp(rsz, 1'($urandom_range(0, 1)), ra, rwd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/store_narrow_rmw.md
Name: store_narrow_rmw

Overview:
- Store-side counterpart of the load-path sign/zero extender. It narrows a 32-bit register value to byte, halfword or word and writes it into word-addressed data memory.
- Sub-word stores use a read-modify-write sequence; word stores write directly.
- It also flags truncation overflow: discarded upper bits that are not the sign/zero extension of the kept bits.
- Sits between the execute stage and the data memory port.

Parameters:
RD_LAT, 1, data-memory read latency in cycles, from mem_rd_en to valid mem_rdata (legal 1..4)
ADDR_W, 32, byte address width

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
req  input  1  store request
ready  output  1  high only in IDLE; a request is accepted when req && ready at a clk edge
size  input  2  store size: 00 byte, 01 half, 10 word, 11 illegal
sel  input  1  1 = signed check, 0 = unsigned check, used for trunc_ovf
addr  input  ADDR_W  byte address
wdata  input  32  register data to store
mem_addr  output  ADDR_W  word address; addr with [1:0] forced to 00
mem_rd_en  output  1  one-cycle read strobe
mem_rdata  input  32  read data, valid RD_LAT cycles after mem_rd_en
mem_wr_en  output  1  one-cycle write strobe
mem_wdata  output  32  merged word to write
done  output  1  one-cycle completion pulse
err  output  1  valid with done: misaligned or illegal size, no memory write occurred
trunc_ovf  output  1  valid with done: truncation lost information

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - ready=1 after reset; all other outputs 0, including mem_addr and mem_wdata.
  - Any in-flight operation is abandoned; no write is issued afterwards.
- Accept at edge T: size, sel, addr and wdata are captured; later input changes are ignored. req while not ready is ignored and not queued.
- States: IDLE, READ, WAIT, WRITE, FAIL. All outputs are registered and Moore-decoded.
- Error path:
  - size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
  - IDLE -> FAIL. In FAIL (cycle T+1): done=1, err=1, trunc_ovf=0, mem_rd_en=0, mem_wr_en=0.
  - FAIL -> IDLE.
- Word store:
  - IDLE -> WRITE.
  - Cycle T+1: mem_wr_en=1, mem_wdata=wdata, done=1.
  - WRITE -> IDLE.
- Byte/half store:
  - IDLE -> READ. Cycle T+1: mem_rd_en=1.
  - READ -> WAIT; a down-counter loaded with RD_LAT-1 runs in WAIT.
  - mem_rdata is sampled at edge T+1+RD_LAT.
  - Cycle T+2+RD_LAT: WRITE, with mem_wr_en=1 and done=1. For RD_LAT=1 that is T+3.
- Lane merge (little-endian):
  - Byte k=addr[1:0]: bits [8k+7:8k] = wdata[7:0]; other bytes come from mem_rdata.
  - Half h=addr[1]: bits [16h+15:16h] = wdata[15:0]; the other half comes from mem_rdata.
- trunc_ovf, with N=8 (byte) or 16 (half):
  - trunc_ovf = (wdata[31:N] != {32-N{sel & wdata[N-1]}}).
  - Always 0 for word stores and on err.
- mem_addr holds the captured word address from the cycle after accept until return to IDLE.
- Throughput:
  - ready returns the cycle after WRITE/FAIL.
  - Word stores: one per 2 cycles. Sub-word stores: one per RD_LAT+3 cycles.
- mem_rdata is ignored outside the sampling edge.
- done, err and trunc_ovf are pulses; they are 0 in every other cycle.

Decomposition:
- Shared header: size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_BAD=2'b11; FSM state encodings.
- Sub-module store_lane_merge (combinational):
  - Inputs: size, addr[1:0], wdata, old word.
  - Outputs: merged word, trunc_ovf (sel as an input).
- The FSM and the latency counter stay in store_narrow_rmw.

Test Plan:
1. Reset mid-op: accept a byte store, then drive rst_n=0 during WAIT. Required: ready=1 and all strobes 0 next cycle, no mem_wr_en ever, a new req is accepted normally after release.
2. Byte store, RD_LAT=1: addr=0x103, wdata=0x000000AB, sel=0, mem_rdata=0x11223344. Required: mem_rd_en at T+1, mem_addr=0x100, mem_wr_en at T+3, mem_wdata=0xAB223344, done=1, trunc_ovf=0.
3. Half store signed, RD_LAT=3: addr=0x202, wdata=0xFFFF8001, sel=1, mem_rdata=0xDEADBEEF. Required: write at T+5, mem_wdata=0x8001BEEF, trunc_ovf=0. Repeat with wdata=0x00008001: trunc_ovf=1.
4. Word store: addr=0x40, wdata=0xCAFEF00D. Required: mem_wr_en and done at T+1, mem_wdata=0xCAFEF00D, mem_rd_en never asserted, ready again at T+2.
5. Misaligned: half store at addr=0x11, then size=11. Required: done=1, err=1 at T+1, no mem_rd_en/mem_wr_en.
6. Busy ignore: hold req high through a byte store. Required: exactly one write per acceptance, inputs changed during WAIT do not alter mem_wdata, next accept occurs at the edge after WRITE.
